// File: rtl/pipe_stage_elastic.sv
// DEPTH-slot collapsing elastic pipeline register with valid/ready, flush and stall hold.
// Optional stall-cycle counter on stall_cnt_o is enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_elastic #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [2:0]        occ_o
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $error("pipe_stage_elastic: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]  v_q, v_d, adv;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [RD_W-1:0]   rd_d   [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [2:0]        occ_q, occ_d;
  logic              chain;

  // A slot may advance when it is empty or everything ahead of it advances.
  always_comb begin
    adv   = '0;
    chain = out_ready_i;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      chain              = ~v_q[DEPTH-1-i] | chain;
      adv[DEPTH-1-i]     = chain;
    end
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    rd_d   = rd_q;
    ctrl_d = ctrl_q;
    if (flush_i) begin
      v_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctrl_d[i] = '0;
      end
    end else begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          v_d[k]    = v_q[k-1];
          data_d[k] = data_q[k-1];
          rd_d[k]   = rd_q[k-1];
          ctrl_d[k] = ctrl_q[k-1];
        end
      end
      if (adv[0]) begin
        v_d[0] = in_valid_i;
        if (in_valid_i) begin
          data_d[0] = data_i;
          rd_d[0]   = rd_i;
          ctrl_d[0] = ctrl_i;
        end
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + 3'(v_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
        ctrl_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      occ_q  <= occ_d;
      data_q <= data_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign in_ready_o  = flush_i | adv[0];
  assign out_valid_o = v_q[DEPTH-1];
  assign data_o      = data_q[DEPTH-1];
  assign rd_o        = rd_q[DEPTH-1];
  assign ctrl_o      = v_q[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
  assign occ_o       = occ_q;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      stall_cnt_d = '0;
    end else if (out_valid_o && !out_ready_i && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register.
- DEPTH-slot elastic pipeline register with valid/ready handshake, bubble collapsing, flush and stall hold.
- Carries a data payload, a destination-register address and a control field; control is never asserted by a bubble.
- Placed between any two core stages: EX/MEM, MEM/WB, or a multi-cycle unit's output.

Parameters:
- DATA_W, 64, payload width in bits (e.g. ALU result concatenated with read data).
- RD_W, 5, destination register address width.
- CTRL_W, 2, control field width (e.g. MemToReg, RegWrite).
- DEPTH, 1, number of register slots; legal 1..4; any other value is a compile-time error.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  slot 0 can accept this cycle.
- data_i  in  DATA_W  payload in.
- rd_i  in  RD_W  destination address in.
- ctrl_i  in  CTRL_W  control bits in.
- flush_i  in  1  synchronous kill of all held entries.
- out_valid_o  out  1  last slot holds a valid entry.
- out_ready_i  in  1  downstream accepts this cycle.
- data_o  out  DATA_W  payload of last slot.
- rd_o  out  RD_W  address of last slot.
- ctrl_o  out  CTRL_W  control of last slot, gated by out_valid_o.
- occ_o  out  3  number of valid slots, 0..DEPTH.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All slot valid bits, data, rd and ctrl registers clear to 0.
  - Resulting outputs: out_valid_o=0, data_o=0, rd_o=0, ctrl_o=0, occ_o=0, in_ready_o=1 once reset is released.
  - Reset asserted mid-transfer discards all entries; nothing is replayed.
- Slots are indexed 0 (input side) to DEPTH-1 (output side).
- Advance rule:
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready_i.
  - adv[k] = ~v[k] | adv[k+1].
  - Ready is combinational; this is a collapsing pipeline, so bubbles are squeezed out.
- in_ready_o = adv[0].
- Input transfer: in_valid_i & in_ready_o. Slot 0 loads data/rd/ctrl and sets v[0].
- Slot k>0 loads from slot k-1 when adv[k]. Its new valid is v[k-1], and its contents are taken from slot k-1 in the same edge.
- Stalled slot (adv[k]=0): data, rd, ctrl and valid all hold unchanged.
- Output transfer: out_valid_o & out_ready_i. The entry leaves at the rising edge.
- Latency: an entry accepted at edge N is visible at the output after edge N+DEPTH-1, provided there is no backpressure. DEPTH=1 gives a one-cycle register, matching the original MEM/WB timing.
- Throughput: 1 entry per cycle with simultaneous input and output transfer, including when all slots are full.
- Empty/full:
  - When occ_o=0, out_valid_o=0.
  - When occ_o=DEPTH and out_ready_i=0, in_ready_o=0.
  - When full and out_ready_i=1, in_ready_o=1 (pass-through).
- ctrl_o is forced to 0 whenever out_valid_o=0. rd_o and data_o are not gated and show the last slot's stored contents.
- Flush (flush_i=1 at an edge):
  - All v[] clear, and all slot ctrl registers clear to 0.
  - The input presented in that cycle is dropped.
  - in_ready_o is forced to 1 during flush.
  - An output handshake in the flush cycle still counts as transferred.
  - occ_o=0 on the next cycle.
- occ_o is registered and updated every edge as the population count of v[].
- Behaviour with out_ready_i=1 and an empty pipe: no spurious out_valid_o.

Optional Feature:
- Macro PIPE_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o, 16 bits.
  - Counts cycles with out_valid_o=1 & out_ready_i=0.
  - Saturates at 0xFFFF.
  - Clears on reset and on flush_i.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset release, DEPTH=1: in_valid_i=1, data_i=0x1234, rd_i=7, ctrl_i=2'b11 -> one edge later out_valid_o=1, data_o=0x1234, rd_o=7, ctrl_o=2'b11, occ_o=1.
- DEPTH=3, out_ready_i=0, push entries A,B,C -> occ_o=3, in_ready_o=0. Then raise out_ready_i with new input D -> A,B,C,D exit in order at one per cycle with no gap.
- DEPTH=2, full, flush_i pulsed for 1 cycle with in_valid_i=1 -> next cycle out_valid_o=0, ctrl_o=0, occ_o=0. The flushed input never appears at the output.
- DEPTH=4, alternate in_valid_i 1/0 with out_ready_i=1 -> bubbles appear on the output with ctrl_o=0, and no entry is duplicated or lost.
- Assert rst_i low mid-stream with occ_o=2 -> outputs go to 0 immediately, without waiting for a clock edge.
- PIPE_STALL_CNT_EN defined, out_valid_o=1, out_ready_i=0 for 5 cycles -> stall_cnt_o=5. Then flush -> stall_cnt_o=0.
